// File: rtl/ifmap_decompressor.sv
// ifmap_decompressor: expands zero-mask-compressed ifmap bytes from the global
// buffer stream into dense 8-element packets for the ifmap buffer.
// Stream format: a header byte (nonzero mask), then one data byte per set bit.
module ifmap_decompressor #(
    parameter int IFMP_DATA_SIZE = 8,
    parameter int CMP_WORD_BYTES = 8,
    parameter int BUF_BYTES      = 16,
    parameter int CNT_W          = 18
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [CNT_W-1:0]                            total_elements,
    input  logic [8*CMP_WORD_BYTES-1:0]                 cmp_data,
    input  logic                                        cmp_valid,
    output logic                                        cmp_ready,
    input  logic                                        ifmap_buffer_req,
    output logic                                        decompressor_ack,
    output logic [8*IFMP_DATA_SIZE+IFMP_DATA_SIZE:0]    decompressed_fifo_packet,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        format_error
);

    typedef enum logic [1:0] {IDLE, HEADER, EXPAND, DONE} state_t;

    state_t                                 state;
    logic [BUF_BYTES-1:0][7:0]              byte_buf;
    logic [4:0]                             fill;
    logic [IFMP_DATA_SIZE-1:0]              mask_q;
    logic [CNT_W-4:0]                       pkt_cnt;
    logic [CNT_W-3:0]                       pkts_total;
    logic [2:0]                             rem;
    logic [IFMP_DATA_SIZE-1:0][7:0]         pkt_data;
    logic [IFMP_DATA_SIZE-1:0]              pkt_vmask;
    logic                                   pkt_valid;

    logic [CNT_W:0]                         total_rnd;
    logic [CNT_W-3:0]                       pkt_cnt_inc;
    logic [3:0]                             pop;
    logic                                   handshake;
    logic                                   slot_free;
    logic                                   accept;
    logic                                   hdr_fire;
    logic                                   exp_fire;
    logic                                   is_last;
    logic [IFMP_DATA_SIZE-1:0]              last_vmask;
    logic                                   fmt_bad;
    logic [4:0]                             consumed;
    logic [4:0]                             base;
    logic [4:0]                             fill_next;
    logic [4:0]                             src;
    logic [4:0]                             off;
    logic [3:0]                             idx;
    logic [IFMP_DATA_SIZE-1:0][7:0]         exp_data;
    logic [BUF_BYTES-1:0][7:0]              buf_next;

    assign total_rnd   = {1'b0, total_elements} + (CNT_W+1)'(7);
    assign pkt_cnt_inc = {1'b0, pkt_cnt} + (CNT_W-2)'(1);
    assign handshake   = pkt_valid & ifmap_buffer_req;
    assign slot_free   = ~pkt_valid | ifmap_buffer_req;
    assign cmp_ready   = busy && (fill <= 5'(BUF_BYTES - CMP_WORD_BYTES)) && (state != DONE);
    assign accept      = cmp_valid & cmp_ready;
    assign is_last     = (pkt_cnt_inc == pkts_total);
    assign hdr_fire    = (state == HEADER) && (fill != 5'd0);
    assign exp_fire    = (state == EXPAND) && (fill >= {1'b0, pop}) && slot_free;

    assign decompressor_ack         = pkt_valid;
    assign decompressed_fifo_packet = {pkt_data, pkt_vmask, pkt_valid};

    // Mask popcount, trimmed last-packet mask and the expanded element data
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < IFMP_DATA_SIZE; i++) begin
            pop = pop + 4'(mask_q[i]);
        end
        last_vmask = '1;
        if (is_last && (rem != 3'd0)) begin
            last_vmask = IFMP_DATA_SIZE'((9'd1 << rem) - 9'd1);
        end
        fmt_bad = |(mask_q & ~last_vmask);
        // Masked-off positions still advance idx so their bytes get consumed.
        idx      = '0;
        exp_data = '0;
        for (int unsigned i = 0; i < IFMP_DATA_SIZE; i++) begin
            if (mask_q[i]) begin
                if (last_vmask[i]) begin
                    exp_data[i] = byte_buf[idx];
                end
                idx = idx + 4'd1;
            end
        end
    end

    // Byte buffer next state: shift consumed bytes out, append accepted word
    always_comb begin
        consumed = '0;
        if (hdr_fire) begin
            consumed = 5'd1;
        end else if (exp_fire) begin
            consumed = {1'b0, pop};
        end
        base      = fill - consumed;
        fill_next = base + (accept ? 5'(CMP_WORD_BYTES) : 5'd0);
        src       = '0;
        off       = '0;
        buf_next  = '0;
        for (int unsigned j = 0; j < BUF_BYTES; j++) begin
            src         = 5'(j) + consumed;
            buf_next[j] = src[4] ? 8'h00 : byte_buf[src[3:0]];
            off         = 5'(j) - base;
            if (accept && (5'(j) >= base) && (off < 5'(CMP_WORD_BYTES))) begin
                buf_next[j] = cmp_data[{off[2:0], 3'b000} +: 8];
            end
        end
    end

    // Layer FSM, byte buffer, packet counter and registered output packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_buf     <= '0;
            fill         <= '0;
            mask_q       <= '0;
            pkt_cnt      <= '0;
            pkts_total   <= '0;
            rem          <= '0;
            pkt_data     <= '0;
            pkt_vmask    <= '0;
            pkt_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            format_error <= 1'b0;
        end else if (start) begin
            byte_buf     <= '0;
            fill         <= '0;
            mask_q       <= '0;
            pkt_cnt      <= '0;
            pkts_total   <= total_rnd[CNT_W:3];
            rem          <= total_elements[2:0];
            pkt_data     <= '0;
            pkt_vmask    <= '0;
            pkt_valid    <= 1'b0;
            format_error <= 1'b0;
            if (total_elements == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= HEADER;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            byte_buf <= buf_next;
            fill     <= fill_next;
            if (handshake) begin
                pkt_valid <= 1'b0;
            end
            case (state)
                HEADER: begin
                    if (hdr_fire) begin
                        mask_q <= byte_buf[0];
                        state  <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (exp_fire) begin
                        pkt_data  <= exp_data;
                        pkt_vmask <= last_vmask;
                        pkt_valid <= 1'b1;
                        pkt_cnt   <= pkt_cnt + 1'b1;
                        if (fmt_bad) begin
                            format_error <= 1'b1;
                        end
                        state <= is_last ? DONE : HEADER;
                    end
                end
                DONE: begin
                    if (busy && (!pkt_valid || handshake)) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_decompressor.sv
// Directed testbench for ifmap_decompressor: builds compressed streams, feeds
// them word by word and checks every dense packet and status flag.
module tb_ifmap_decompressor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [17:0] total_elements;
    logic [63:0] cmp_data;
    logic        cmp_valid;
    logic        cmp_ready;
    logic        ifmap_buffer_req;
    logic        decompressor_ack;
    logic [72:0] decompressed_fifo_packet;
    logic        busy;
    logic        done;
    logic        format_error;

    int vectors;
    int errs;

    logic [7:0]  bq[$];
    logic [63:0] wq[$];
    logic [72:0] exp_q[$];
    logic [72:0] p;
    logic [72:0] held;
    logic        acc;
    logic [7:0]  pats [4];

    ifmap_decompressor #(
        .IFMP_DATA_SIZE (8),
        .CMP_WORD_BYTES (8),
        .BUF_BYTES      (16),
        .CNT_W          (18)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start                    (start),
        .total_elements           (total_elements),
        .cmp_data                 (cmp_data),
        .cmp_valid                (cmp_valid),
        .cmp_ready                (cmp_ready),
        .ifmap_buffer_req         (ifmap_buffer_req),
        .decompressor_ack         (decompressor_ack),
        .decompressed_fifo_packet (decompressed_fifo_packet),
        .busy                     (busy),
        .done                     (done),
        .format_error             (format_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [72:0] mk(input logic [63:0] d, input logic [7:0] vm);
        return {d, vm, 1'b1};
    endfunction

    function automatic logic [7:0] ev(input int k, input int i);
        return 8'((k * 8 + i) | 128);
    endfunction

    task automatic present();
        if (wq.size() > 0) begin
            cmp_valid = 1'b1;
            cmp_data  = wq[0];
        end else begin
            cmp_valid = 1'b0;
            cmp_data  = '0;
        end
    endtask

    // One clock: offer the head word, note acceptance, retire it after the edge
    task automatic tick();
        present();
        @(negedge clk);
        acc = cmp_valid && cmp_ready;
        @(posedge clk);
        #1;
        if (acc) void'(wq.pop_front());
        present();
    endtask

    task automatic seal();
        logic [63:0] w;
        while ((bq.size() % 8) != 0) bq.push_back(8'hEE);
        while (bq.size() > 0) begin
            w = '0;
            for (int i = 0; i < 8; i++) w[8*i +: 8] = bq.pop_front();
            wq.push_back(w);
        end
    endtask

    task automatic do_start(input logic [17:0] total);
        bq.delete();
        wq.delete();
        exp_q.delete();
        present();
        total_elements = total;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ack(input int max_ticks);
        int n;
        n = 0;
        while (!decompressor_ack && n < max_ticks) begin
            tick();
            n++;
        end
        chk("ack_wait", 73'(decompressor_ack), 73'(1));
    endtask

    task automatic take();
        ifmap_buffer_req = 1'b1;
        tick();
        ifmap_buffer_req = 1'b0;
    endtask

    // 227-element layer: 28 full packets with varied headers, last header 0x05
    task automatic build_layer();
        logic [7:0]  hdr;
        logic [63:0] d;
        for (int k = 0; k < 29; k++) begin
            hdr = (k == 28) ? 8'h05 : pats[k % 4];
            bq.push_back(hdr);
            d = '0;
            for (int i = 0; i < 8; i++) begin
                if (hdr[i]) begin
                    bq.push_back(ev(k, i));
                    d[8*i +: 8] = ev(k, i);
                end
            end
            exp_q.push_back(mk(d, (k == 28) ? 8'h07 : 8'hFF));
        end
        seal();
    endtask

    initial begin
        vectors = 0;
        errs = 0;
        pats[0] = 8'hFF; pats[1] = 8'h00; pats[2] = 8'hA5; pats[3] = 8'h3C;
        rst_n = 1'b0;
        start = 1'b0;
        total_elements = '0;
        cmp_data = '0;
        cmp_valid = 1'b0;
        ifmap_buffer_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt", decompressed_fifo_packet, '0);
        chk("rst_flags", 73'({decompressor_ack, busy, done, format_error, cmp_ready}), '0);
        rst_n = 1'b1;
        tick();
        chk("idle_flags", 73'({decompressor_ack, busy, done, cmp_ready}), '0);

        // Full packet spanning two words
        do_start(18'd8);
        chk("t1_start", 73'({decompressor_ack, busy, done}), 73'(3'b010));
        bq.push_back(8'hFF);
        for (int i = 0; i < 8; i++) bq.push_back(8'(8'h11 + i));
        seal();
        wait_ack(20);
        chk("t1_pkt", decompressed_fifo_packet, mk(64'h1817161514131211, 8'hFF));
        take();
        chk("t1_done", 73'({done, busy, cmp_ready, decompressor_ack}), 73'(4'b1000));

        // Two all-zero packets
        do_start(18'd16);
        chk("t2_done_clr", 73'(done), '0);
        bq.push_back(8'h00);
        bq.push_back(8'h00);
        seal();
        for (int k = 0; k < 2; k++) begin
            wait_ack(20);
            chk("t2_pkt", decompressed_fifo_packet, mk(64'h0, 8'hFF));
            take();
        end
        chk("t2_done", 73'({done, busy, cmp_ready, decompressor_ack}), 73'(4'b1000));

        // 227-element line with a backpressure window on packet 5
        do_start(18'd227);
        build_layer();
        for (int k = 0; k < 29; k++) begin
            if (k == 5) begin
                wait_ack(20);
                held = decompressed_fifo_packet;
                for (int c = 0; c < 5; c++) begin
                    tick();
                    chk("bp_ack", 73'(decompressor_ack), 73'(1));
                    chk("bp_hold", decompressed_fifo_packet, held);
                end
                chk("bp_ready", 73'(cmp_ready), '0);
            end else if (k == 6) begin
                wait_ack(2);
            end else begin
                wait_ack(20);
            end
            if (k == 28) chk("t3_last_busy", 73'({busy, done}), 73'(2'b10));
            chk($sformatf("t3_pkt%0d", k), decompressed_fifo_packet, exp_q[k]);
            take();
        end
        chk("t3_done", 73'({done, busy, decompressor_ack}), 73'(3'b100));

        // Restart mid-layer after three packets
        do_start(18'd227);
        build_layer();
        for (int k = 0; k < 3; k++) begin
            wait_ack(20);
            chk("t5_old_pkt", decompressed_fifo_packet, exp_q[k]);
            take();
        end
        repeat (2) tick();
        do_start(18'd16);
        chk("t5_restart", 73'({decompressor_ack, done, busy}), 73'(3'b001));
        bq.push_back(8'h81); bq.push_back(8'hAA); bq.push_back(8'hBB);
        bq.push_back(8'hFF);
        for (int i = 0; i < 8; i++) bq.push_back(8'(i + 1));
        seal();
        wait_ack(20);
        chk("t5_pkt0", decompressed_fifo_packet, mk(64'hBB000000000000AA, 8'hFF));
        take();
        wait_ack(20);
        chk("t5_pkt1", decompressed_fifo_packet, mk(64'h0807060504030201, 8'hFF));
        take();
        chk("t5_done", 73'({done, busy}), 73'(2'b10));

        // Header bit beyond the last packet's remainder
        do_start(18'd3);
        bq.push_back(8'h21); bq.push_back(8'h5A); bq.push_back(8'h6B);
        seal();
        wait_ack(20);
        chk("t6_pkt", decompressed_fifo_packet, mk(64'h5A, 8'h07));
        chk("t6_fmt", 73'(format_error), 73'(1));
        take();
        repeat (3) tick();
        chk("t6_sticky", 73'({format_error, done}), 73'(2'b11));
        do_start(18'd0);
        chk("t6_fmt_clr", 73'({format_error, decompressor_ack}), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/ifmap_decompressor.md
Name: ifmap_decompressor

Overview:
- Source end of the decompressed-ifmap packet handshake. It reads zero-mask-compressed ifmap bytes from the global buffer stream and expands them into dense 8-element packets of type DECOMRPESS_FIFO_PACKET.
- Packets are delivered on request to the ifmap buffer, with one transfer per cycle where ifmap_buffer_req & decompressor_ack.
- Each transfer covers one layer's ifmap, whose length is programmed at start.

Parameters:
- IFMP_DATA_SIZE, 8, elements (bytes) per output packet.
- CMP_WORD_BYTES, 8, bytes per compressed input word.
- BUF_BYTES, 16, internal byte realignment buffer depth.
- CNT_W, 18, width of element count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; latch total_elements, flush state, begin layer.
- total_elements  in  CNT_W  dense elements in this layer (e.g. 227*227*3=154587).
- cmp_data  in  64  compressed word; byte0 = bits[7:0] is first in stream.
- cmp_valid  in  1  cmp_data valid.
- cmp_ready  out  1  word accepted when cmp_valid & cmp_ready.
- ifmap_buffer_req  in  1  consumer request.
- decompressor_ack  out  1  packet available; equals decompressed_fifo_packet.packet_valid.
- decompressed_fifo_packet  out  73  fields: data[7:0][7:0], valid_mask[7:0], packet_valid.
- busy  out  1  layer in progress.
- done  out  1  all packets of layer transferred; held until next start.
- format_error  out  1  sticky header-mask error; cleared by start.

Behaviour:
- Stream format: a header byte gives the nonzero mask for the next 8 dense elements (bit i = element i). It is followed by popcount(header) data bytes, in ascending element order. Zero elements are emitted as 0x00 with valid_mask bit = 1.
- Reset / start values: all outputs 0 (cmp_ready, ack, packet fields, busy, done, format_error). The buffer fill count, packet counter and FSM go to IDLE.
- start has priority over all other activity, including mid-layer:
  - The buffer is flushed, any held packet is dropped (packet_valid 0 in the next cycle), and done and format_error are cleared.
  - pkts_total = (total_elements+7)>>3 and rem = total_elements[2:0] are latched.
  - The FSM enters HEADER; busy = 1. If total_elements = 0, the FSM goes to DONE instead.
- Byte buffer:
  - cmp_ready = busy & (fill <= BUF_BYTES-CMP_WORD_BYTES) & state != DONE.
  - An accepted word is appended at position fill.
  - Consumed bytes shift out from position 0.
  - Append and consume in the same cycle: new fill = fill + 8 - consumed.
- FSM states: IDLE, HEADER, EXPAND, DONE.
  - HEADER: if fill >= 1, latch mask = buf[0], consume 1 byte, go to EXPAND. Otherwise stay.
  - EXPAND: fires if fill >= popcount(mask) and the output slot is free (packet_valid = 0, or a handshake occurs this cycle). When it fires:
    - Build data[i] from consecutive buffer bytes where mask[i] = 1, and 0 elsewhere.
    - Consume popcount(mask) bytes, load the output register, increment the packet counter.
    - If this was packet pkts_total, go to DONE; otherwise go to HEADER.
  - DONE: entered when the final packet is loaded. done = 1 and busy = 0 once that final packet handshakes. Remaining buffer bytes are ignored. The FSM stays in DONE until start.
- Output register:
  - decompressor_ack = packet_valid. It never depends combinationally on ifmap_buffer_req.
  - The packet is held stable while ack = 1 and req = 0.
  - packet_valid is cleared on a handshake unless a new packet loads in the same cycle.
- valid_mask:
  - 0xFF for every packet except the last.
  - For the last packet when rem != 0, valid_mask = (1<<rem)-1.
  - If that last header has any bit set at index >= rem: those data bytes are still consumed, data is forced to 0 at masked-off positions, and format_error is set.
- Throughput: at most one packet per 2 cycles (HEADER + EXPAND). Latency from the first word accepted with a full packet's bytes to ack is ≤ 3 cycles.
- Counter widths: packet counter is CNT_W-3 bits; popcount is 4 bits; fill is 5 bits (0..16).

Test Plan:
1. Full packet spanning words: total=8; words {hdr 0xFF, b1..b7}, {b8, pad}. Required: one packet, valid_mask 0xFF, data = b1..b8, then done=1 after handshake and cmp_ready=0.
2. All-zero packets: total=16; word bytes {0x00, 0x00, pad…}. Required: two packets, data all 0, valid_mask 0xFF, exactly 2 bytes consumed; done=1.
3. Layer 1 line length: total=227. Required: 29 packets, first 28 with mask 0xFF, last with valid_mask 0x07; done after the 29th handshake.
4. Backpressure: hold req=0 for 5 cycles with a packet pending. Required: ack stays 1, packet bits unchanged, fill saturates ≤ 16, cmp_ready=0 when fill > 8. On req=1, the next packet follows within 2 cycles.
5. Start mid-layer: start pulse after packet 3 of 29. Required: next cycle ack=0, done=0, busy=1; counter restarts at 0; first packet comes from the new stream only.
6. Format error: total=3; header 0x21 (bit 5 set) with 2 data bytes. Required: valid_mask 0x07, data[0] = byte1, data[5] not emitted, format_error=1 until the next start.
